// File: rtl/lfsr_payload_gen.sv
// rtl/lfsr_payload_gen.sv - serialises 32-bit LFSR words MSB-first into an AXI-Stream byte frame
// Optional frame counter port and register enabled by LFSR_PAYLOAD_STATS_EN.
module lfsr_payload_gen #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  input  logic [31:0]          lfsr_value,
  output logic                 lfsr_enable,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
`ifdef LFSR_PAYLOAD_STATS_EN
  ,
  output logic [31:0]          frame_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [1:0]           r_byte_idx;
  logic [31:0]          r_word_buf;
  logic                 r_busy;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic [7:0]           w_byte;
  logic                 w_handshake;
`ifdef LFSR_PAYLOAD_STATS_EN
  logic [31:0]          r_frame_count;
`endif

  assign w_handshake = r_tvalid && m_axis_tready;

  always_comb begin
    w_byte = 8'h00;
    case (r_byte_idx)
      2'd0:    w_byte = r_word_buf[31:24];
      2'd1:    w_byte = r_word_buf[23:16];
      2'd2:    w_byte = r_word_buf[15:8];
      default: w_byte = r_word_buf[7:0];
    endcase
  end

  // The LFSR advances on the LOAD->SEND edge, the same edge word_buf captures its pre-advance value.
  assign lfsr_enable   = (r_state == ST_LOAD);
  assign busy          = r_busy;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tdata  = r_tvalid ? w_byte : 8'h00;
`ifdef LFSR_PAYLOAD_STATS_EN
  assign frame_count   = r_frame_count;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_remaining   <= '0;
      r_byte_idx    <= 2'd0;
      r_word_buf    <= 32'h0;
      r_busy        <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
`ifdef LFSR_PAYLOAD_STATS_EN
      r_frame_count <= 32'h0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && (length != '0)) begin
            r_remaining <= length;
            r_byte_idx  <= 2'd0;
            r_busy      <= 1'b1;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_word_buf <= lfsr_value;
          r_tvalid   <= 1'b1;
          r_tlast    <= (r_remaining == LEN_WIDTH'(1));
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_handshake) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
`ifdef LFSR_PAYLOAD_STATS_EN
              r_frame_count <= r_frame_count + 32'd1;
`endif
            end else if (r_byte_idx == 2'd3) begin
              r_byte_idx <= 2'd0;
              r_tvalid   <= 1'b0;
              r_tlast    <= 1'b0;
              r_state    <= ST_LOAD;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_tlast    <= (r_remaining == LEN_WIDTH'(2));
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_payload_gen.sv
// tb/tb_lfsr_payload_gen.sv - randomized self-checking bench for lfsr_payload_gen
module tb_lfsr_payload_gen;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] length;
  logic          busy;
  logic [31:0]   lfsr_q = 32'h0;
  logic          lfsr_enable;
  logic [7:0]    tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
`ifdef LFSR_PAYLOAD_STATS_EN
  logic [31:0]   frame_count;
`endif

  lfsr_payload_gen #(.LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .length        (length),
    .busy          (busy),
    .lfsr_value    (lfsr_q),
    .lfsr_enable   (lfsr_enable),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
`ifdef LFSR_PAYLOAD_STATS_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  // Stand-in for the upstream 32-bit LFSR instance
  logic        seed_load;
  logic [31:0] seed;
  always @(posedge clk) begin
    if (seed_load) lfsr_q <= seed;
    else if (lfsr_enable) lfsr_q <= lfsr_next(lfsr_q);
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic          n_start = 1'b0;
  logic [LW-1:0] n_len   = '0;
  logic          n_rst   = 1'b1;
  logic          n_seed_load = 1'b0;
  int            ready_mode  = 0;

  bit         exp_busy = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];
  int         frame_len, cyc_start, en_cnt, frames, cyc;
  bit         frame_done, first_seen, all_ready;
  bit         prev_v, prev_r, prev_l, prev_en;
  logic [7:0] prev_d;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic build_expected(input int len, input logic [31:0] w0);
    logic [31:0] w;
    logic [31:0] sh;
    w = w0;
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      if (k > 0 && (k % 4) == 0) w = lfsr_next(w);
      sh = w >> (24 - 8 * (k % 4));
      exp_q.push_back(sh[7:0]);
    end
  endtask

  task automatic monitor();
    bit         nxt_busy;
    logic [7:0] eb;
    if (rst) begin
      chk(busy === 1'b0 && tvalid === 1'b0 && tlast === 1'b0 && lfsr_enable === 1'b0 && tdata === 8'h00,
          "reset_outputs", {busy, tvalid, tlast, lfsr_enable, tdata}, 64'h0);
`ifdef LFSR_PAYLOAD_STATS_EN
      chk(frame_count === 32'h0, "reset_frame_count", frame_count, 0);
`endif
      exp_busy = 1'b0; exp_q.delete(); frames = 0;
      prev_v = 1'b0; prev_en = 1'b0;
      return;
    end
    nxt_busy = exp_busy;
    chk(busy === exp_busy, "busy", busy, exp_busy);
    chk(!(tvalid && !exp_busy), "tvalid_idle", tvalid, 0);
    chk(!(lfsr_enable && (prev_en || !exp_busy)), "enable_pulse", {prev_en, lfsr_enable}, 0);
`ifdef LFSR_PAYLOAD_STATS_EN
    chk(frame_count == 32'(frames), "frame_count", frame_count, frames);
`endif
    if (prev_v && !prev_r)
      chk(tvalid && tdata == prev_d && tlast == prev_l, "hold", {tvalid, tdata, tlast}, {1'b1, prev_d, prev_l});
    if (lfsr_enable) en_cnt++;
    if (tvalid && exp_busy && !first_seen) begin
      first_seen = 1'b1;
      chk(cyc == cyc_start + 2, "latency", cyc - cyc_start, 2);
    end
    if (tvalid && tready) begin
      chk(exp_q.size() != 0, "extra_byte", tdata, 0);
      if (exp_q.size() != 0) begin
        eb = exp_q.pop_front();
        got_q.push_back(tdata);
        chk(tdata == eb, "tdata", tdata, eb);
        chk(tlast == (exp_q.size() == 0), "tlast", tlast, exp_q.size() == 0);
        if (exp_q.size() == 0) begin
          chk(en_cnt == (frame_len + 3) / 4, "enable_count", en_cnt, (frame_len + 3) / 4);
          if (all_ready)
            chk(cyc == cyc_start + frame_len + (frame_len + 3) / 4, "frame_cycles",
                cyc - cyc_start, frame_len + (frame_len + 3) / 4);
          nxt_busy = 1'b0;
          frames++;
          frame_done = 1'b1;
        end
      end
    end
    if (!exp_busy && start && length != '0) begin
      build_expected(int'(length), lfsr_q);
      frame_len = int'(length); cyc_start = cyc; en_cnt = 0;
      first_seen = 1'b0; got_q.delete(); all_ready = (ready_mode == 0);
      nxt_busy = 1'b1;
    end
    prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast; prev_en = lfsr_enable;
    exp_busy = nxt_busy;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    start     = n_start;
    length    = n_len;
    rst       = n_rst;
    seed_load = n_seed_load;
    seed      = seed;
    tready    = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed = s; n_seed_load = 1'b1; step(); n_seed_load = 1'b0; step();
  endtask

  task automatic run_frame(input int len, input int mode);
    ready_mode = mode; frame_done = 1'b0;
    n_start = 1'b1; n_len = LW'(len); step();
    n_start = 1'b0;
    for (int i = 0; i < 400 && !frame_done; i++) step();
    chk(frame_done, "frame_timeout", frame_done, 1);
    step();
  endtask

  initial begin
    logic [7:0] lit4[4];
    logic [7:0] lit6[6];
    int f0;
    lit4 = '{8'h12, 8'h34, 8'h56, 8'h78};
    lit6 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h24, 8'h68};
    rst = 1'b1; start = 1'b0; length = '0; tready = 1'b1; seed_load = 1'b0; seed = 32'h0; cyc = 0;
    for (int i = 0; i < 3; i++) step();
    n_rst = 1'b0; step();

    load_seed(32'h12345678);
    run_frame(4, 0);
    chk(got_q.size() == 4, "t1_size", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk(got_q[i] == lit4[i], "t1_byte", got_q[i], lit4[i]);

    load_seed(32'h12345678);
    run_frame(6, 0);
    chk(got_q.size() == 6, "t2_size", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk(got_q[i] == lit6[i], "t2_byte", got_q[i], lit6[i]);

    load_seed(32'hCAFEF00D);
    run_frame(9, 0);
    ref_q = got_q;
    load_seed(32'hCAFEF00D);
    run_frame(9, 1);
    chk(got_q.size() == ref_q.size(), "bp_size", got_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) chk(got_q[i] == ref_q[i], "bp_byte", got_q[i], ref_q[i]);

    ready_mode = 0;
    n_start = 1'b1; n_len = '0; step(); step();
    n_start = 1'b0;
    for (int i = 0; i < 6; i++) step();

    f0 = frames; frame_done = 1'b0;
    n_start = 1'b1; n_len = LW'(12); step();
    for (int i = 0; i < 200 && !frame_done; i++) begin
      n_start = ((i % 5) == 2); n_len = LW'(7); step();
    end
    n_start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk(frames == f0 + 1, "busy_start_ignored", frames - f0, 1);

    ready_mode = 0; frame_done = 1'b0;
    n_start = 1'b1; n_len = LW'(8); step(); n_start = 1'b0;
    for (int i = 0; i < 50 && got_q.size() < 3; i++) step();
    chk(got_q.size() == 3, "reset_point", got_q.size(), 3);
    n_rst = 1'b1; step(); step();
    n_rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    run_frame(8, 0);
    chk(got_q.size() == 8, "post_reset_frame", got_q.size(), 8);

    for (int f = 0; f < 25; f++) begin
      load_seed($urandom);
      run_frame(int'($urandom_range(1, 20)), int'($urandom_range(0, 1)));
    end

    ready_mode = 0;
    n_rst = 1'b1; step(); n_rst = 1'b0; step();
    run_frame(1, 0); run_frame(5, 1); run_frame(4, 0);
`ifdef LFSR_PAYLOAD_STATS_EN
    chk(frame_count == 32'd3, "stats_three_frames", frame_count, 3);
`else
    chk(frames == 3, "three_frames", frames, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
